// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream register slice: stage state
// encoding and payload width helpers.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  function automatic int keep_w(input int data_width);
    return data_width / 8;
  endfunction

  // Packed beat layout, MSB first: {tdata, tkeep, tuser, tlast}
  function automatic int payload_w(input int data_width, input int user_width);
    return data_width + keep_w(data_width) + user_width + 1;
  endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// One skid-buffer stage: main register M drives the output, skid register K
// catches the beat that arrives while the output is stalled.
module axis_skid_stage
  import axis_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  stage_state_e     state_reg;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             ready_reg;
  logic             valid_reg;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid && ready_reg;
  assign out_fire = valid_reg && out_ready;

  // ready/valid are kept as explicit registers so neither side sees a
  // combinational path through this stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          ready_reg <= 1'b1;
          if (in_fire) begin
            main_reg  <= in_data;
            valid_reg <= 1'b1;
            state_reg <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_reg <= in_data;
          end else if (in_fire) begin
            skid_reg  <= in_data;
            ready_reg <= 1'b0;
            state_reg <= ST_SKID;
          end else if (out_fire) begin
            valid_reg <= 1'b0;
            state_reg <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_reg  <= skid_reg;
            ready_reg <= 1'b1;
            state_reg <= ST_FULL;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = ready_reg;
  assign out_data  = main_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/axis_reg_slice.sv
// AXI4-Stream register slice: STAGES cascaded skid stages (or a wire when
// STAGES = 0) plus m-side beat and packet counters.
module axis_reg_slice
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_EN    = 0,
  parameter int USER_WIDTH = 1,
  parameter int STAGES     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt
);

  localparam int KEEP_W = keep_w(DATA_WIDTH);
  localparam int PAY_W  = payload_w(DATA_WIDTH, USER_WIDTH);

  logic [KEEP_W-1:0]    keep_in;
  logic [PAY_W-1:0]     s_payload;
  logic [PAY_W-1:0]     m_payload;
  logic                 m_fire;
  logic [CNT_WIDTH-1:0] beat_cnt_reg;
  logic [CNT_WIDTH-1:0] pkt_cnt_reg;

  // With tkeep disabled every byte is forced valid before entering the chain.
  assign keep_in   = s_tkeep | {KEEP_W{(KEEP_EN == 0)}};
  assign s_payload = {s_tdata, keep_in, s_tuser, s_tlast};

  generate
    if (STAGES == 0) begin : g_bypass
      assign m_payload = s_payload;
      assign m_tvalid  = s_tvalid;
      assign s_tready  = m_tready;
    end else begin : g_chain
      logic [PAY_W-1:0] pay     [0:STAGES];
      logic             valid_c [0:STAGES];
      logic             ready_c [0:STAGES];

      assign pay[0]          = s_payload;
      assign valid_c[0]      = s_tvalid;
      assign s_tready        = ready_c[0];
      assign ready_c[STAGES] = m_tready;
      assign m_payload       = pay[STAGES];
      assign m_tvalid        = valid_c[STAGES];

      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        axis_skid_stage #(
          .WIDTH(PAY_W)
        ) u_stage (
          .clk      (clk),
          .reset    (reset),
          .in_data  (pay[gi]),
          .in_valid (valid_c[gi]),
          .in_ready (ready_c[gi]),
          .out_data (pay[gi+1]),
          .out_valid(valid_c[gi+1]),
          .out_ready(ready_c[gi+1])
        );
      end
    end
  endgenerate

  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = m_payload;

  assign m_fire = m_tvalid && m_tready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else if (m_fire) begin
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if (m_tlast) begin
        pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      end
    end
  end

  assign beat_cnt = beat_cnt_reg;
  assign pkt_cnt  = pkt_cnt_reg;

endmodule

// File: tb/tb_axis_reg_slice.sv
// Directed and randomised checks of axis_reg_slice: a 2-stage 32-bit slice
// with tkeep/tuser, and a pass-through slice with a 4-bit counter.
module tb_axis_reg_slice;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       mready;
    logic [7:0] exp_tdata;
    logic       exp_tvalid;
    logic       exp_tlast;
    logic       exp_sready;
  } byp_vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  // Main instance: STAGES = 2, DATA_WIDTH = 32, KEEP_EN = 1
  logic [31:0] s_tdata  = '0;
  logic [3:0]  s_tkeep  = '0;
  logic [1:0]  s_tuser  = '0;
  logic        s_tlast  = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [1:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic [15:0] beat_cnt;
  logic [15:0] pkt_cnt;

  // Bypass instance: STAGES = 0, DATA_WIDTH = 8, CNT_WIDTH = 4
  logic [7:0] b_s_tdata  = '0;
  logic       b_s_tkeep  = 1'b0;
  logic       b_s_tuser  = 1'b0;
  logic       b_s_tlast  = 1'b0;
  logic       b_s_tvalid = 1'b0;
  logic       b_m_tready = 1'b0;
  logic       b_s_tready;
  logic [7:0] b_m_tdata;
  logic       b_m_tkeep;
  logic       b_m_tuser;
  logic       b_m_tlast;
  logic       b_m_tvalid;
  logic [3:0] b_beat_cnt;
  logic [3:0] b_pkt_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    first_s  = -1;
  int    first_m  = -1;
  int    last_m   = -1;
  bit    s_acc    = 1'b0;
  bit    rand_en  = 1'b0;
  beat_t sb[$];

  axis_reg_slice #(
    .DATA_WIDTH(32), .KEEP_EN(1), .USER_WIDTH(2), .STAGES(2), .CNT_WIDTH(16)
  ) u_main (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  axis_reg_slice #(
    .DATA_WIDTH(8), .KEEP_EN(0), .USER_WIDTH(1), .STAGES(0), .CNT_WIDTH(4)
  ) u_byp (
    .clk(clk), .reset(reset),
    .s_tdata(b_s_tdata), .s_tkeep(b_s_tkeep), .s_tuser(b_s_tuser), .s_tlast(b_s_tlast),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tuser(b_m_tuser), .m_tlast(b_m_tlast),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
    .beat_cnt(b_beat_cnt), .pkt_cnt(b_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: predicts the handshakes of the coming rising edge.
  task automatic sample();
    beat_t b;
    s_acc = 1'b0;
    if (!reset) begin
      sb.delete();
      return;
    end
    if (s_tvalid && s_tready) begin
      s_acc = 1'b1;
      b = {s_tdata, s_tkeep, s_tuser, s_tlast};
      sb.push_back(b);
      if (first_s < 0) first_s = cyc;
    end
    if (m_tvalid && m_tready) begin
      check("sb_has_beat", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("beat_payload", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'(b));
      end
      if (first_m < 0) first_m = cyc;
      last_m = cyc;
    end
  endtask

  // Sample at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_en) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input beat_t b);
    int guard;
    guard = 0;
    {s_tdata, s_tkeep, s_tuser, s_tlast} = b;
    s_tvalid = 1'b1;
    do begin
      tick();
      guard++;
    end while (!s_acc && guard < 500);
    check("push_accepted", 64'(s_acc), 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    m_tready = 1'b1;
    while ((sb.size() != 0 || m_tvalid) && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_empty", 64'(sb.size() == 0 && !m_tvalid), 64'd1);
  endtask

  initial begin
    byp_vec_t vecs[5];
    beat_t    b;
    int       k;
    int       n_last;

    //             tdata  vld   last  mrdy  exp_d  exp_v exp_l exp_srdy
    vecs[0] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1};

    // Reset held for 5 cycles: everything reads zero
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_tready), 64'd0);
      check("rst_m_payload", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'd0);
      check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    end
    reset = 1'b1;
    check("rel_s_tready_before_edge", 64'(s_tready), 64'd0);
    tick();
    check("rel_s_tready_first_edge", 64'(s_tready), 64'd1);

    // Streaming 0x01..0x10, one packet, no stalls
    m_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      b = '{data: 32'(i), keep: 4'hF, user: 2'd1, last: (i == 16)};
      push(b);
    end
    drain();
    check("stream_latency", 64'(first_m - first_s), 64'd2);
    check("stream_back_to_back", 64'(last_m - first_m), 64'd15);
    check("stream_beat_cnt", 64'(beat_cnt), 64'd16);
    check("stream_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Backpressure: 2 stages hold exactly 4 beats
    m_tready = 1'b0;
    k = 0;
    {s_tdata, s_tkeep, s_tuser, s_tlast} = {32'hA0, 4'hF, 2'd2, 1'b0};
    s_tvalid = 1'b1;
    repeat (8) begin
      tick();
      if (s_acc) begin
        k++;
        s_tdata = 32'hA0 + 32'(k);
      end
    end
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_s_tready_low", 64'(s_tready), 64'd0);
    check("bp_m_tvalid_held", 64'(m_tvalid), 64'd1);
    check("bp_m_tdata_head", 64'(m_tdata), 64'hA0);
    s_tvalid = 1'b0;
    drain();
    check("bp_beat_cnt", 64'(beat_cnt), 64'd20);

    // Random stall with random sideband
    n_last = 0;
    rand_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      b.data = $urandom;
      b.keep = 4'($urandom_range(0, 15));
      b.user = 2'($urandom_range(0, 3));
      b.last = ($urandom_range(0, 7) == 0);
      if (b.last) n_last++;
      push(b);
    end
    rand_en = 1'b0;
    drain();
    check("rand_beat_cnt", 64'(beat_cnt), 64'd1020);
    check("rand_pkt_cnt", 64'(pkt_cnt), 64'(1 + n_last));

    // Mid-packet reset: 3 of 6 beats inside, reset mid-cycle
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = '{data: 32'h100 + 32'(i), keep: 4'h3, user: 2'd3, last: 1'b0};
      push(b);
    end
    tick();
    tick();
    check("mid_m_tvalid_before", 64'(m_tvalid), 64'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_async_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_async_s_tready", 64'(s_tready), 64'd0);
    check("mid_async_m_tdata", 64'(m_tdata), 64'd0);
    check("mid_async_beat_cnt", 64'(beat_cnt), 64'd0);
    check("mid_async_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk);
    #1;
    tick();
    reset = 1'b1;
    tick();
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = '{data: 32'h200 + 32'(i), keep: 4'(i + 1), user: 2'(i), last: (i == 5)};
      push(b);
    end
    drain();
    check("mid_fresh_beat_cnt", 64'(beat_cnt), 64'd6);
    check("mid_fresh_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Counter wrap on the 4-bit pass-through instance
    b_s_tvalid = 1'b1;
    b_m_tready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b_s_tdata = 8'(i);
      b_s_tlast = (i == 16);
      tick();
      if (i == 15) check("wrap_beat_cnt_16", 64'(b_beat_cnt), 64'd0);
    end
    check("wrap_beat_cnt_17", 64'(b_beat_cnt), 64'd1);
    check("wrap_pkt_cnt", 64'(b_pkt_cnt), 64'd1);

    // Pass-through vectors: outputs follow inputs within the cycle
    for (int i = 0; i < 5; i++) begin
      b_s_tdata  = vecs[i].tdata;
      b_s_tvalid = vecs[i].tvalid;
      b_s_tlast  = vecs[i].tlast;
      b_m_tready = vecs[i].mready;
      #1;
      check($sformatf("byp_tdata[%0d]", i), 64'(b_m_tdata), 64'(vecs[i].exp_tdata));
      check($sformatf("byp_tvalid[%0d]", i), 64'(b_m_tvalid), 64'(vecs[i].exp_tvalid));
      check($sformatf("byp_tlast[%0d]", i), 64'(b_m_tlast), 64'(vecs[i].exp_tlast));
      check($sformatf("byp_s_tready[%0d]", i), 64'(b_s_tready), 64'(vecs[i].exp_sready));
      check($sformatf("byp_tkeep[%0d]", i), 64'(b_m_tkeep), 64'd1);
      tick();
    end
    b_s_tvalid = 1'b0;
    check("byp_beat_cnt", 64'(b_beat_cnt), 64'd3);
    check("byp_pkt_cnt", 64'(b_pkt_cnt), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_reg_slice.md
Name: axis_reg_slice

Overview:
Parametrised AXI4-Stream register slice. It breaks the combinational paths on both the data/valid path and the ready path. The slice is a chain of STAGES skid-buffer stages and sustains one beat per clock with no bubbles. It sits between any two AXIS blocks in the 8-bit streaming datapath and is generalised in width, sideband, and depth. A packet/beat counter is provided for debug.

Parameters:
DATA_WIDTH, 8, tdata width in bits (multiple of 8).
KEEP_EN, 0, 1 = carry tkeep (DATA_WIDTH/8 bits); 0 = tkeep port tied high internally and m_tkeep driven all-ones.
USER_WIDTH, 1, tuser width, carried alongside tdata.
STAGES, 1, number of cascaded skid stages (1..8); 0 = combinational pass-through.
CNT_WIDTH, 16, width of the beat and packet counters.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronised externally.
s_tdata  in  DATA_WIDTH  upstream data.
s_tkeep  in  DATA_WIDTH/8  upstream byte enables.
s_tuser  in  USER_WIDTH  upstream sideband.
s_tlast  in  1  upstream end of packet.
s_tvalid  in  1  upstream valid.
s_tready  out  1  registered ready to upstream.
m_tdata  out  DATA_WIDTH  downstream data.
m_tkeep  out  DATA_WIDTH/8  downstream byte enables.
m_tuser  out  USER_WIDTH  downstream sideband.
m_tlast  out  1  downstream end of packet.
m_tvalid  out  1  downstream valid.
m_tready  in  1  downstream ready.
beat_cnt  out  CNT_WIDTH  beats accepted at the m side.
pkt_cnt  out  CNT_WIDTH  tlast beats accepted at the m side.

Behaviour:
- Reset (reset = 0, async):
  - m_tvalid = 0, s_tready = 0, m_tdata/m_tkeep/m_tuser/m_tlast = 0, beat_cnt = pkt_cnt = 0.
  - All stages go to EMPTY, and any in-flight beats are discarded.
  - s_tready rises on the first clk edge after reset deasserts.
- Handshake:
  - A beat transfers when valid && ready on a rising edge.
  - m_tvalid is never withdrawn, and the m-side payload is held stable, until accepted.
  - s_tready depends only on registered state, never combinationally on m_tready.
- Per-stage FSM with main register M and skid register K:
  - EMPTY (ready = 1, out_valid = 0): an input beat loads M, go to FULL.
  - FULL (ready = 1, out_valid = 1):
    - in && out: M <= in, stay.
    - in && !out: K <= in, go to SKID.
    - !in && out: go to EMPTY.
    - neither: stay.
  - SKID (ready = 0, out_valid = 1): on out, M <= K, go to FULL. An input cannot arrive here since ready = 0.
- Latency: STAGES cycles from s accept to m_tvalid when unstalled. Throughput is 1 beat/cycle under continuous valid/ready.
- Capacity: 2*STAGES beats when m_tready is held low. s_tready falls only after every stage is in SKID.
- Ordering: beats exit in input order; tlast/tkeep/tuser stay bound to their beat.
- STAGES = 0: all m outputs are wired directly to s, and s_tready = m_tready. The counters still operate.
- Counters:
  - beat_cnt increments on each m_tvalid && m_tready.
  - pkt_cnt increments when that beat also has m_tlast = 1.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- KEEP_EN = 0: the s_tkeep input is ignored and m_tkeep is all-ones.
- Reset asserted mid-packet: the partial packet is lost and the counters clear. No recovery is performed.

Decomposition:
- Package axis_pkg holds:
  - the stage-state encoding (ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2);
  - the payload packing helper (width = DATA_WIDTH + DATA_WIDTH/8 + USER_WIDTH + 1);
  - the KEEP_W localparam rule.
- Sub-module axis_skid_stage: one FSM, M/K registers, and a packed payload bus. The top-level axis_reg_slice instantiates it STAGES times in a generate loop and adds the counters.

Test Plan:
1. Reset check: hold reset = 0 for 5 cycles, then release → all outputs 0 during reset, and s_tready = 1 on the first edge after release.
2. Streaming: STAGES = 2; send 0x01..0x10 with tlast on 0x10 and m_tready = 1 throughout →
   - m_tdata 0x01..0x10 back-to-back starting 2 cycles after the first accept;
   - beat_cnt = 16, pkt_cnt = 1.
3. Backpressure: STAGES = 2; hold m_tready = 0, then send beats 0xA0.. →
   - exactly 4 beats accepted, then s_tready = 0;
   - release m_tready → 0xA0, 0xA1, 0xA2, 0xA3 out in order, with no drop or duplicate.
4. Random stall: m_tready toggled randomly at 50% for 1000 beats with random tkeep/tuser (KEEP_EN = 1, DATA_WIDTH = 32) → a scoreboard matches every beat, sideband included.
5. Mid-packet reset: assert reset after 3 of 6 beats → m_tvalid drops to 0 asynchronously (before the next edge) and the counters read 0; a fresh packet afterwards passes cleanly.
6. Wrap and bypass:
   - CNT_WIDTH = 4: 17 accepted beats → beat_cnt = 1.
   - STAGES = 0: m_tdata equals s_tdata in the same cycle, and s_tready follows m_tready.
